mult_div_unit: RTL and testbench

//  Multi-cycle iterative multiply/divide unit owning the HI/LO registers. It replaces
//  the single-cycle mult/div path in the execute-stage ALU. Sits beside the ALU in

---
 rtl/mult_div_if.sv | 27 ++
 rtl/mult_div_unit.sv | 175 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
// The master side issues operations; the slave side owns HI/LO and reports busy/done/stall.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             sig_start;
    logic [2:0]       sig_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             sig_mf_req;
    logic             sig_cancel;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             sig_busy;
    logic             sig_done;
    logic             sig_stall;

    modport master (
        output sig_start, sig_op, src_a, src_b, sig_mf_req, sig_cancel,
        input  hi_reg, lo_reg, sig_busy, sig_done, sig_stall
    );

    modport slave (
        input  sig_start, sig_op, src_a, src_b, sig_mf_req, sig_cancel,
        output hi_reg, lo_reg, sig_busy, sig_done, sig_stall
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit owning HI/LO.
// Magnitudes are processed unsigned in CALC; signs are restored in FIX.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    mult_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t             state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [WIDTH:0]     acc_hi_reg;
    logic [WIDTH-1:0]   acc_lo_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   hi_data_reg;
    logic [WIDTH-1:0]   lo_data_reg;
    logic               is_div_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               arith_op;
    logic               op_div;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign arith_op  = (bus.sig_op == OP_MULT) || (bus.sig_op == OP_MULTU) ||
                       (bus.sig_op == OP_DIV)  || (bus.sig_op == OP_DIVU);
    assign op_div    = (bus.sig_op == OP_DIV) || (bus.sig_op == OP_DIVU);
    assign op_signed = (bus.sig_op == OP_MULT) || (bus.sig_op == OP_DIV);
    assign a_neg     = op_signed & bus.src_a[WIDTH-1];
    assign b_neg     = op_signed & bus.src_b[WIDTH-1];
    assign mag_a     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign mag_b     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;

    // Multiply: shift-add with the multiplier consumed from the LSB of acc_lo.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     mul_add;
    // Divide: restoring step with the quotient shifted in at the LSB of acc_lo.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;

    assign mul_sum   = acc_hi_reg + {1'b0, opnd_reg};
    assign mul_add   = acc_lo_reg[0] ? mul_sum : acc_hi_reg;
    assign div_shift = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_ge    = (div_shift >= {1'b0, opnd_reg});

    always_comb begin
        step_hi = '0;
        step_lo = '0;
        if (is_div_reg) begin
            step_hi = div_ge ? div_diff : div_shift;
            step_lo = {acc_lo_reg[WIDTH-2:0], div_ge};
        end else begin
            {step_hi, step_lo} = {mul_add, acc_lo_reg} >> 1;
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod     = {acc_hi_reg[WIDTH-1:0], acc_lo_reg};
    assign prod_fix = neg_q_reg ? (~prod + 1'b1) : prod;

    // A zero divisor leaves the remainder equal to |a|, which the dividend-sign
    // correction turns back into the raw src_a; only the quotient needs forcing.
    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (is_div_reg) begin
            fix_hi = neg_r_reg ? (~acc_hi_reg[WIDTH-1:0] + 1'b1) : acc_hi_reg[WIDTH-1:0];
            if (opnd_reg == '0)
                fix_lo = '1;
            else
                fix_lo = neg_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
        end else begin
            {fix_hi, fix_lo} = prod_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            opnd_reg    <= '0;
            hi_data_reg <= '0;
            lo_data_reg <= '0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.sig_start) begin
                        if (arith_op) begin
                            state_reg  <= CALC;
                            busy_reg   <= 1'b1;
                            count_reg  <= '0;
                            acc_hi_reg <= '0;
                            acc_lo_reg <= op_div ? mag_a : mag_b;
                            opnd_reg   <= op_div ? mag_b : mag_a;
                            is_div_reg <= op_div;
                            neg_q_reg  <= a_neg ^ b_neg;
                            neg_r_reg  <= a_neg;
                        end else if (bus.sig_op == OP_MTHI) begin
                            hi_data_reg <= bus.src_a;
                        end else if (bus.sig_op == OP_MTLO) begin
                            lo_data_reg <= bus.src_a;
                        end
                    end
                end
                CALC: begin
                    if (bus.sig_cancel) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_hi_reg <= step_hi;
                        acc_lo_reg <= step_lo;
                        count_reg  <= count_reg + 1'b1;
                        if (count_reg == LAST_STEP) begin
                            state_reg <= FIX;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                FIX: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    if (!bus.sig_cancel) begin
                        hi_data_reg <= fix_hi;
                        lo_data_reg <= fix_lo;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi_reg    = hi_data_reg;
    assign bus.lo_reg    = lo_data_reg;
    assign bus.sig_busy  = busy_reg;
    assign bus.sig_done  = done_reg;
    assign bus.sig_stall = busy_reg & (bus.sig_mf_req | bus.sig_start);
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;
    int   pass_count;
    int   check_count;

    mult_div_if #(.WIDTH(32)) bus();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi, lo} from the architectural definition using wide integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: res = ua * ub;
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'd0;
        if (sel == 1) return 32'h8000_0000;
        if (sel == 2) return 32'hFFFF_FFFF;
        if (sel <= 4) return 32'($urandom_range(1, 50));
        return $urandom;
    endfunction

    // Issues one op and waits (bounded) for busy to fall; reports what it saw.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int cycles, output int dones);
        @(negedge clk);
        bus.sig_start = 1'b1;
        bus.sig_op    = op;
        bus.src_a     = a;
        bus.src_b     = b;
        @(posedge clk);
        #1;
        bus.sig_start = 1'b0;
        bus.sig_op    = 3'd0;
        cycles = 0;
        dones  = 0;
        while (bus.sig_busy && cycles < 200) begin
            if (bus.sig_done) dones++;
            @(posedge clk);
            #1;
            cycles++;
        end
        hi = bus.hi_reg;
        lo = bus.lo_reg;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d done=%0d", op, a, b, hi, lo,
                 cycles, dones);
    endtask

    task automatic test_reset();
        bus.sig_start  = 1'b0;
        bus.sig_op     = 3'd0;
        bus.src_a      = '0;
        bus.src_b      = '0;
        bus.sig_mf_req = 1'b0;
        bus.sig_cancel = 1'b0;
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        @(negedge clk);
        bus.sig_mf_req = 1'b1;
        bus.sig_start  = 1'b1;
        #1;
        check_count++;
        if ({bus.hi_reg, bus.lo_reg} !== 64'd0) $display("FAIL reset_hilo: got %h expected 0", {bus.hi_reg, bus.lo_reg});
        else pass_count++;
        check_count++;
        if ({bus.sig_busy, bus.sig_done, bus.sig_stall} !== 3'b000)
            $display("FAIL reset_flags: got busy/done/stall=%b expected 000", {bus.sig_busy, bus.sig_done, bus.sig_stall});
        else pass_count++;
        bus.sig_mf_req = 1'b0;
        bus.sig_start  = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [8] = '{3'd2, 3'd1, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3};
        logic [31:0] as  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'd5, 32'd64, 32'hFFFF_FFF9};
        logic [31:0] bs  [8] = '{32'hFFFF_FFFF, 32'd7, 32'h1234_5678, 32'd2,
                                 32'hFFFF_FFFF, 32'd0, 32'd7, 32'd0};
        logic [63:0] want[8] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB, 64'd0,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                                 64'h0000_0005_FFFF_FFFF, 64'h0000_0001_0000_0009,
                                 64'hFFFF_FFF9_FFFF_FFFF};
        logic [31:0] hi, lo;
        int cyc, dn;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], hi, lo, cyc, dn);
            check_count++;
            if ({hi, lo} !== want[i]) $display("FAIL directed_%0d: got %h expected %h", i, {hi, lo}, want[i]);
            else pass_count++;
            check_count++;
            if (cyc !== 33 || dn !== 1) $display("FAIL latency_%0d: got cycles=%0d done=%0d expected 33/1", i, cyc, dn);
            else pass_count++;
        end
    endtask

    task automatic test_random();
        logic [31:0] hi, lo, a, b;
        logic [2:0]  op;
        logic [63:0] exp;
        int cyc, dn;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = rand_operand();
            b  = rand_operand();
            exp = ref_result(op, a, b);
            run_op(op, a, b, hi, lo, cyc, dn);
            check_count++;
            if ({hi, lo} !== exp || cyc !== 33)
                $display("FAIL random_%0d op=%0d: got %h cycles=%0d expected %h cycles=33", i, op, {hi, lo}, cyc, exp);
            else pass_count++;
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] hi, lo, lo_before;
        int cyc, dn;
        lo_before = bus.lo_reg;
        run_op(3'd5, 32'h0000_1234, 32'hDEAD_BEEF, hi, lo, cyc, dn);
        check_count++;
        if (hi !== 32'h1234 || lo !== lo_before || cyc !== 0)
            $display("FAIL mthi: got hi=%h lo=%h cycles=%0d expected hi=00001234 lo=%h cycles=0", hi, lo, cyc, lo_before);
        else pass_count++;
        run_op(3'd6, 32'hCAFE_0001, 32'd0, hi, lo, cyc, dn);
        check_count++;
        if (hi !== 32'h1234 || lo !== 32'hCAFE_0001)
            $display("FAIL mtlo: got hi=%h lo=%h expected 00001234/cafe0001", hi, lo);
        else pass_count++;
        run_op(3'd0, 32'h1111_1111, 32'd3, hi, lo, cyc, dn);
        run_op(3'd7, 32'h2222_2222, 32'd3, hi, lo, cyc, dn);
        check_count++;
        if ({hi, lo} !== 64'h0000_1234_CAFE_0001 || bus.sig_busy !== 1'b0)
            $display("FAIL op_none: got %h busy=%b expected 00001234cafe0001 busy=0", {hi, lo}, bus.sig_busy);
        else pass_count++;
    endtask

    task automatic test_stall_busy();
        logic [31:0] a, b;
        logic [63:0] exp;
        int cyc, bad;
        a = $urandom;
        b = $urandom;
        exp = ref_result(3'd1, a, b);
        @(negedge clk);
        bus.sig_start = 1'b1;
        bus.sig_op    = 3'd1;
        bus.src_a     = a;
        bus.src_b     = b;
        @(posedge clk);
        #1;
        // Keep start asserted with a different op to show it is ignored while busy.
        bus.sig_op     = 3'd4;
        bus.src_a      = ~a;
        bus.src_b      = 32'd3;
        bus.sig_mf_req = 1'b1;
        cyc = 0;
        bad = 0;
        while (bus.sig_busy && cyc < 200) begin
            if (bus.sig_stall !== 1'b1) bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.sig_start = 1'b0;
        $display("op=1 a=%h b=%h (start held) -> hi=%h lo=%h cycles=%0d", a, b, bus.hi_reg, bus.lo_reg, cyc);
        check_count++;
        if (bad !== 0 || cyc !== 33) $display("FAIL stall_while_busy: got low-stall cycles=%0d busy=%0d expected 0/33", bad, cyc);
        else pass_count++;
        check_count++;
        if (bus.sig_stall !== 1'b0) $display("FAIL stall_after: got %b expected 0", bus.sig_stall);
        else pass_count++;
        check_count++;
        if ({bus.hi_reg, bus.lo_reg} !== exp) $display("FAIL start_ignored: got %h expected %h", {bus.hi_reg, bus.lo_reg}, exp);
        else pass_count++;
        bus.sig_mf_req = 1'b0;
        @(negedge clk);
        check_count++;
        if (bus.sig_busy !== 1'b0) $display("FAIL no_restart: got busy=%b expected 0", bus.sig_busy);
        else pass_count++;
    endtask

    task automatic test_cancel();
        logic [31:0] hi, lo, a, b;
        logic [63:0] exp;
        int cyc, dn, seen;
        run_op(3'd5, 32'hAAAA_5555, 32'd0, hi, lo, cyc, dn);
        run_op(3'd6, 32'h1234_ABCD, 32'd0, hi, lo, cyc, dn);
        a = $urandom | 32'd1;
        b = $urandom | 32'd1;
        @(negedge clk);
        bus.sig_start = 1'b1;
        bus.sig_op    = 3'd2;
        bus.src_a     = a;
        bus.src_b     = b;
        @(posedge clk);
        #1;
        bus.sig_start = 1'b0;
        seen = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (bus.sig_done) seen++;
        end
        @(negedge clk);
        bus.sig_cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.sig_cancel = 1'b0;
        $display("op=2 a=%h b=%h cancelled in CALC -> busy=%b hi=%h lo=%h", a, b, bus.sig_busy, bus.hi_reg, bus.lo_reg);
        check_count++;
        if (bus.sig_busy !== 1'b0) $display("FAIL cancel_idle: got busy=%b expected 0", bus.sig_busy);
        else pass_count++;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.sig_done) seen++;
        end
        check_count++;
        if ({bus.hi_reg, bus.lo_reg} !== 64'hAAAA_5555_1234_ABCD || seen !== 0)
            $display("FAIL cancel_hold: got %h done=%0d expected aaaa55551234abcd done=0", {bus.hi_reg, bus.lo_reg}, seen);
        else pass_count++;
        // Start and cancel together in IDLE: the start must win.
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        exp = ref_result(3'd3, a, b);
        @(negedge clk);
        bus.sig_start  = 1'b1;
        bus.sig_cancel = 1'b1;
        bus.sig_op     = 3'd3;
        bus.src_a      = a;
        bus.src_b      = b;
        @(posedge clk);
        #1;
        bus.sig_start  = 1'b0;
        bus.sig_cancel = 1'b0;
        cyc = 0;
        while (bus.sig_busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("op=3 a=%h b=%h with cancel -> hi=%h lo=%h cycles=%0d", a, b, bus.hi_reg, bus.lo_reg, cyc);
        check_count++;
        if ({bus.hi_reg, bus.lo_reg} !== exp || cyc !== 33)
            $display("FAIL start_beats_cancel: got %h cycles=%0d expected %h cycles=33", {bus.hi_reg, bus.lo_reg}, cyc, exp);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo, a, b, exp_hi, exp_lo;
        logic [2:0]  op;
        int cyc, dn, bad;
        exp_hi = bus.hi_reg;
        exp_lo = bus.lo_reg;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = rand_operand();
            b  = rand_operand();
            if (op == 3'd5) exp_hi = a;
            else if (op == 3'd6) exp_lo = a;
            else {exp_hi, exp_lo} = ref_result(op, a, b);
            run_op(op, a, b, hi, lo, cyc, dn);
            if ({hi, lo} !== {exp_hi, exp_lo}) bad++;
        end
        check_count++;
        if (bad !== 0 || {bus.hi_reg, bus.lo_reg} !== {exp_hi, exp_lo})
            $display("FAIL back_to_back: got %0d wrong, final %h expected 0 wrong, final %h", bad, {bus.hi_reg, bus.lo_reg}, {exp_hi, exp_lo});
        else pass_count++;
    endtask

    task automatic test_async_reset();
        logic [31:0] hi, lo;
        int cyc, dn;
        run_op(3'd5, 32'h5A5A_5A5A, 32'd0, hi, lo, cyc, dn);
        @(negedge clk);
        bus.sig_start  = 1'b1;
        bus.sig_op     = 3'd1;
        bus.src_a      = $urandom;
        bus.src_b      = $urandom;
        bus.sig_mf_req = 1'b1;
        @(posedge clk);
        #1;
        bus.sig_start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-op -> hi=%h lo=%h busy=%b", bus.hi_reg, bus.lo_reg, bus.sig_busy);
        check_count++;
        if ({bus.hi_reg, bus.lo_reg} !== 64'd0 || bus.sig_busy !== 1'b0 || bus.sig_stall !== 1'b0)
            $display("FAIL async_reset: got %h busy=%b stall=%b expected 0/0/0", {bus.hi_reg, bus.lo_reg}, bus.sig_busy, bus.sig_stall);
        else pass_count++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.sig_mf_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_count++;
        if (bus.sig_busy !== 1'b0 || bus.sig_done !== 1'b0)
            $display("FAIL post_reset_idle: got busy=%b done=%b expected 0/0", bus.sig_busy, bus.sig_done);
        else pass_count++;
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        test_reset();
        test_directed();
        test_random();
        test_mthi_mtlo();
        test_stall_busy();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
